inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Fetch stage of the pipelined RV64 core and the requesting end of the instruction-memory read interface. It owns the program counter, drives the byte address into instruction memory, captures the returned 32-bit word, and queues {pc, inst} pairs in a 2-entry buffer toward decode under a valid/ready handshake. Control-flow redirects from EX flush the buffer and restart fetch at the target.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset
- BUF_DEPTH, 2, fetch buffer entries (fixed at 2 for this revision)
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- inst_addr  out  64  byte address to instruction memory; equals the PC register
- inst  in  32  instruction word from memory, combinational same-cycle response to inst_addr
- redirect_valid  in  1  taken branch/jump from EX this cycle
- redirect_pc  in  64  redirect target
- out_valid  out  1  buffer head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_pc  out  64  PC of head entry
- out_inst  out  32  instruction of head entry

## Operation
- State: pc register, 2-entry FIFO of {pc[63:0], inst[31:0]}, occupancy count 0..2.
- pop = out_valid & out_ready. fetch = (count < 2) | pop.
- Normal cycle, no redirect: if fetch, push {pc, inst}, then pc <= pc + 4; else pc holds and no push.
- Simultaneous push and pop: count unchanged, order preserved; legal when full.
- Redirect (priority over push/pop): FIFO cleared (count <= 0), pc <= {redirect_pc[63:2], 2'b00}; the word on inst this cycle is discarded; pop is still reported to decode but has no effect on ordering since all entries drop.
- Reset (priority over everything): pc <= RESET_PC, count <= 0.
- PC arithmetic is modulo 2^64; wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 with no flag. No bounds check against memory size.
- Outputs when empty: out_valid 0, out_pc 0, out_inst 32'h00000013 (NOP).

## Timing
- Reset values: inst_addr = RESET_PC, out_valid 0, out_pc 0, out_inst NOP.
- Fetch-to-output latency: 1 cycle (word fetched at edge N is visible on out_* after edge N, i.e. cycle N+1).
- Throughput: 1 instruction/cycle with out_ready held high; no bubbles in steady state.
- Backpressure: with out_ready low, exactly 2 words are fetched then inst_addr holds steady until a pop.
- Redirect penalty: out_valid 0 in the cycle after redirect; target instruction valid the cycle after that.
- out_* depend only on registered state (no combinational path from inst or out_ready to out_*). inst_addr is registered. fetch depends combinationally on out_ready.

## Structure
- Shared package: NOP_INST = 32'h00000013, INST_BYTES = 4, PC_W = 64, INST_W = 32.
- One sub-module: fetch_buffer (2-entry synchronous FIFO, push/pop/flush, count output). PC and next-PC logic stay in the top level.

## Test plan
- Reset, out_ready=1, memory loaded with the boot image: first cycle after release out_valid=1, out_pc=0, out_inst=0x00000013; at out_pc=0x10 out_inst=0x00900413; one output per cycle.
- out_ready held 0 after reset: inst_addr advances 0 -> 4 -> 8 then holds at 8; out_pc stays 0; on out_ready=1 decode sees 0, 4, 8, 0xC consecutively with no gap or duplicate.
- Buffer full, redirect_valid=1 with redirect_pc=0x180: next cycle out_valid=0; following cycle out_pc=0x180, out_inst=0x04890263.
- redirect_pc=0x183: inst_addr becomes 0x180.
- Redirect, pop and reset asserted together: next cycle inst_addr=RESET_PC, out_valid=0.
- pc forced near top via redirect to 64'hFFFF_FFFF_FFFF_FFFC (memory model returns NOP): next fetch address is 0, no stall.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg
//   Shared constants and types for the fetch stage: instruction/PC widths,
//   the canonical NOP encoding, and the {pc, inst} buffer entry type.
package inst_fetch_unit_pkg;

  localparam int PC_W       = 64;
  localparam int INST_W     = 32;
  localparam int INST_BYTES = 4;

  // addi x0, x0, 0
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if
//   Bundles the fetch stage's external traffic: the instruction-memory read
//   port (inst_addr/inst), the EX redirect input and the decode-side
//   valid/ready output.
//   master : fetch unit side (drives inst_addr and out_*)
//   slave  : environment side (memory, EX and decode)
interface inst_fetch_unit_if;
  import inst_fetch_unit_pkg::*;

  logic [PC_W-1:0]   inst_addr;
  logic [INST_W-1:0] inst;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;

  modport master (
    output inst_addr, out_valid, out_pc, out_inst,
    input  inst, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  inst_addr, out_valid, out_pc, out_inst,
    output inst, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/inst_fetch_unit_fetch_buffer.sv
// fetch_buffer
//   Two-entry synchronous FIFO of {pc, inst} pairs between fetch and decode.
//   Entry 0 is always the head; a pop shifts entry 1 down.
//   clk, reset   : clock, synchronous active-high reset
//   push         : write push_entry at the tail (ignored when full without pop)
//   pop          : drop the head (ignored when empty)
//   flush        : discard all entries
//   push_entry   : entry to enqueue
//   head, valid  : head entry and its valid flag (registered state only)
//   count        : occupancy 0..2
module fetch_buffer
  import inst_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic         valid,
  output logic [1:0]   count
);

  fetch_entry_t entries [2];
  logic         pop_ok;
  logic         full;

  assign valid  = (count != 2'd0);
  assign full   = (count == 2'd2);
  assign pop_ok = pop & valid;
  assign head   = entries[0];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop_ok})
        2'b10: begin
          if (!full) begin
            entries[count[0]] <= push_entry;
            count             <= count + 2'd1;
          end
        end
        2'b01: begin
          entries[0] <= entries[1];
          count      <= count - 2'd1;
        end
        // Push and pop together: occupancy is unchanged, the new word lands
        // behind whatever survives the pop.
        2'b11: begin
          if (full) begin
            entries[0] <= entries[1];
            entries[1] <= push_entry;
          end else begin
            entries[0] <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//   Fetch stage: owns the PC, reads instruction memory combinationally at
//   inst_addr = pc, and queues {pc, inst} toward decode in a 2-entry buffer.
//   An EX redirect flushes the buffer and restarts fetch at the word-aligned
//   target; reset has priority over everything.
//   clk    : clock, all state on rising edge
//   reset  : synchronous active-high
//   bus    : inst_fetch_unit_if.master (inst_addr/inst, redirect_*, out_*)
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 64'h0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  inst_fetch_unit_if.master   bus
);

  logic [PC_W-1:0] pc;
  logic [1:0]      count;
  logic            buf_valid;
  fetch_entry_t    head;
  fetch_entry_t    new_entry;
  logic            pop;
  logic            fetch;
  logic            push;

  // fetch looks at out_ready combinationally so a full buffer still streams
  // one word per cycle while decode is accepting.
  assign pop   = buf_valid & bus.out_ready;
  assign fetch = (count < 2'(BUF_DEPTH)) | pop;
  // The word returned during a redirect belongs to the wrong path.
  assign push  = fetch & ~bus.redirect_valid;

  assign new_entry.pc   = pc;
  assign new_entry.inst = bus.inst;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc <= bus.redirect_pc & ~PC_W'(INST_BYTES - 1);
    end else if (fetch) begin
      pc <= pc + PC_W'(INST_BYTES);
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .push_entry (new_entry),
    .head       (head),
    .valid      (buf_valid),
    .count      (count)
  );

  assign bus.inst_addr = pc;
  assign bus.out_valid = buf_valid;
  assign bus.out_pc    = buf_valid ? head.pc   : '0;
  assign bus.out_inst  = buf_valid ? head.inst : NOP_INST;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam logic [63:0] TB_RESET_PC = 64'h0;
  localparam logic [63:0] TOP_PC      = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inst_fetch_unit_if bus();

  inst_fetch_unit #(.RESET_PC(TB_RESET_PC), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory: boot-image words at known addresses, NOP near the
  // top of the address space, a scrambled pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    case (a)
      64'h0:   return 32'h0000_0013;
      64'h10:  return 32'h0090_0413;
      64'h180: return 32'h0489_0263;
      default: begin
        if (a[63:32] == 32'hFFFF_FFFF) return NOP_INST;
        return (lo * 32'h9E37_79B1) ^ 32'h1234_5678;
      end
    endcase
  endfunction

  assign bus.inst = mem_word(bus.inst_addr);

  int tests = 0;
  int fails = 0;

  // Reference model: the PC and an ordered queue of {pc, inst} words that
  // decode has yet to accept.
  logic [63:0] m_pc;
  logic [95:0] m_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic rst, input logic rv, input logic [63:0] rpc, input logic rdy);
    logic        pop;
    logic        fetch;
    logic [95:0] dropped;
    reset              = rst;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    pop = (m_q.size() > 0) && rdy;
    if (rst) begin
      m_pc = TB_RESET_PC;
      m_q.delete();
    end else if (rv) begin
      m_q.delete();
      m_pc = {rpc[63:2], 2'b00};
    end else begin
      fetch = (m_q.size() < 2) || pop;
      if (pop) dropped = m_q.pop_front();
      if (fetch) begin
        m_q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 64'd4;
      end
    end
    @(posedge clk);
    #1;
    check("model_inst_addr", bus.inst_addr, m_pc);
    check("model_out_valid", 64'(bus.out_valid), 64'(m_q.size() > 0));
    check("model_out_pc",    bus.out_pc,   (m_q.size() > 0) ? m_q[0][95:32] : 64'h0);
    check("model_out_inst",  64'(bus.out_inst), (m_q.size() > 0) ? 64'(m_q[0][31:0]) : 64'(NOP_INST));
  endtask

  initial begin
    logic        r_rst, r_rv, r_rdy;
    logic [63:0] r_pc;

    // Reset state
    tick(1, 0, 0, 1);
    tick(1, 0, 0, 1);
    check("rst_inst_addr", bus.inst_addr, TB_RESET_PC);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_out_pc", bus.out_pc, 64'h0);
    check("rst_out_inst", 64'(bus.out_inst), 64'h13);

    // Boot stream with out_ready high
    tick(0, 0, 0, 1);
    check("boot_valid", 64'(bus.out_valid), 64'h1);
    check("boot_pc0", bus.out_pc, 64'h0);
    check("boot_inst0", 64'(bus.out_inst), 64'h13);
    for (int i = 1; i <= 4; i++) begin
      tick(0, 0, 0, 1);
      check("boot_stream_pc", bus.out_pc, 64'(4 * i));
    end
    check("boot_inst10", 64'(bus.out_inst), 64'h0090_0413);

    // Backpressure: two fetches then inst_addr holds
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    check("bp_addr4", bus.inst_addr, 64'h4);
    tick(0, 0, 0, 0);
    check("bp_addr8", bus.inst_addr, 64'h8);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    check("bp_hold8", bus.inst_addr, 64'h8);
    check("bp_head0", bus.out_pc, 64'h0);
    tick(0, 0, 0, 1);
    check("bp_seq4", bus.out_pc, 64'h4);
    tick(0, 0, 0, 1);
    check("bp_seq8", bus.out_pc, 64'h8);
    tick(0, 0, 0, 1);
    check("bp_seqC", bus.out_pc, 64'hC);
    check("bp_seqC_valid", 64'(bus.out_valid), 64'h1);

    // Redirect with buffer full
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 64'h180, 0);
    check("redir_bubble", 64'(bus.out_valid), 64'h0);
    tick(0, 0, 0, 0);
    check("redir_pc", bus.out_pc, 64'h180);
    check("redir_inst", 64'(bus.out_inst), 64'h0489_0263);

    // Misaligned redirect target
    tick(0, 1, 64'h183, 1);
    check("redir_align", bus.inst_addr, 64'h180);

    // Redirect + pop + reset together
    tick(0, 0, 0, 0);
    tick(1, 1, 64'h400, 1);
    check("rrp_addr", bus.inst_addr, TB_RESET_PC);
    check("rrp_valid", 64'(bus.out_valid), 64'h0);

    // PC wrap at the top of the address space
    tick(0, 1, TOP_PC, 1);
    check("wrap_addr_top", bus.inst_addr, TOP_PC);
    tick(0, 0, 0, 1);
    check("wrap_addr0", bus.inst_addr, 64'h0);
    check("wrap_head_pc", bus.out_pc, TOP_PC);
    check("wrap_head_inst", 64'(bus.out_inst), 64'(NOP_INST));
    tick(0, 0, 0, 1);
    check("wrap_no_stall", bus.out_pc, 64'h0);
    check("wrap_addr4", bus.inst_addr, 64'h4);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom_range(0, 99) < 2);
      r_rv  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0)
        r_pc = {32'hFFFF_FFFF, 32'($urandom_range(32'hFFFF_FFF0, 32'hFFFF_FFFF))};
      else
        r_pc = {32'h0, 32'($urandom_range(0, 4095))};
      r_rdy = ($urandom_range(0, 99) < 65);
      tick(r_rst, r_rv, r_pc, r_rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
